oam_dma: RTL and testbench



---
 rtl/oam_dma.sv | 91 +++++++++
 tb/tb_oam_dma.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: on a write to the DMA register, masters the MMU read port and
// copies NUM_BYTES bytes from page {src,8'h00} into sprite attribute memory.
module oam_dma #(
    parameter int NUM_BYTES = 160
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iDmaWe,
    input  logic [7:0]  iDmaData,
    output logic [7:0]  oDMA,
    output logic [15:0] oMcuAddr,
    output logic        oMcuReadRequest,
    input  logic [7:0]  iMcuReadData,
    input  logic        iMcuReadValid,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic        oBusy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

    state_t     state;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] dataLatch;
    logic [7:0] srcPage;

    // Echo RAM (E000-FDFF) mirrors C000-DDFF.
    always_comb begin
        srcPage = iDmaData;
        if (iDmaData >= 8'hE0) srcPage = iDmaData - 8'h20;
    end

    // The latch only changes on the WAIT->WRITE edge, so it doubles as the held OAM data.
    assign oOamData = dataLatch;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state           <= IDLE;
            index           <= '0;
            page            <= '0;
            dataLatch       <= '0;
            oDMA            <= '0;
            oMcuAddr        <= '0;
            oMcuReadRequest <= 1'b0;
            oOamWe          <= 1'b0;
            oOamAddr        <= '0;
            oBusy           <= 1'b0;
        end else begin
            oMcuReadRequest <= 1'b0;
            oOamWe          <= 1'b0;
            if (iDmaWe) begin
                // Trigger from IDLE and restart from any other state share this path.
                state           <= REQ;
                page            <= srcPage;
                oDMA            <= iDmaData;
                index           <= '0;
                oMcuAddr        <= {srcPage, 8'h00};
                oMcuReadRequest <= 1'b1;
                oBusy           <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: state <= IDLE;
                    REQ:  state <= WAIT;
                    WAIT: begin
                        if (iMcuReadValid) begin
                            dataLatch <= iMcuReadData;
                            oOamWe    <= 1'b1;
                            oOamAddr  <= index;
                            state     <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (index == LAST_INDEX) begin
                            state    <= IDLE;
                            oBusy    <= 1'b0;
                            oMcuAddr <= '0;
                        end else begin
                            index           <= index + 8'd1;
                            oMcuAddr        <= {page, index + 8'd1};
                            oMcuReadRequest <= 1'b1;
                            state           <= REQ;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized MMU latency and data checked
// against a transfer-level reference model (page mapping + expected write list).
module tb_oam_dma;
    logic        clk = 1'b0;
    logic        rst;
    logic        dmaWe, dmaWe1;
    logic [7:0]  dmaData, dmaData1;
    logic [7:0]  dmaReg, dmaReg1;
    logic [15:0] mcuAddr, mcuAddr1;
    logic        mcuReq, mcuReq1;
    logic [7:0]  rdData, rdData1;
    logic        rdValid, rdValid1;
    logic        oamWe, oamWe1;
    logic [7:0]  oamAddr, oamAddr1;
    logic [7:0]  oamData, oamData1;
    logic        busy, busy1;

    always #5 clk = ~clk;

    oam_dma #(.NUM_BYTES(160)) dut (
        .iClock(clk), .iReset(rst), .iDmaWe(dmaWe), .iDmaData(dmaData), .oDMA(dmaReg),
        .oMcuAddr(mcuAddr), .oMcuReadRequest(mcuReq), .iMcuReadData(rdData),
        .iMcuReadValid(rdValid), .oOamWe(oamWe), .oOamAddr(oamAddr), .oOamData(oamData),
        .oBusy(busy)
    );

    oam_dma #(.NUM_BYTES(1)) dut1 (
        .iClock(clk), .iReset(rst), .iDmaWe(dmaWe1), .iDmaData(dmaData1), .oDMA(dmaReg1),
        .oMcuAddr(mcuAddr1), .oMcuReadRequest(mcuReq1), .iMcuReadData(rdData1),
        .iMcuReadValid(rdValid1), .oOamWe(oamWe1), .oOamAddr(oamAddr1), .oOamData(oamData1),
        .oBusy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] writeQ[$];
    logic [15:0] readQ[$];
    int          latQ[$];
    int          busyCycles;

    bit          latMode = 1'b0;
    int          fixedLat = 1;
    bit          strayEn = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [15:0] pendAddr = '0;

    function automatic logic [7:0] mapPage(input logic [7:0] d);
        return (d >= 8'hE0) ? d - 8'h20 : d;
    endfunction

    // MMU model: answers each request after a chosen latency, optionally injects stray valids.
    initial begin
        rdValid = 1'b0;
        rdData  = '0;
        forever begin
            @(negedge clk);
            rdValid = 1'b0;
            if (!busy) pending = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    rdValid = 1'b1;
                    rdData  = mem[pendAddr];
                    pending = 1'b0;
                end
            end else if (strayEn && $urandom_range(0, 2) == 0) begin
                rdValid = 1'b1;
                rdData  = 8'($urandom);
            end
            if (mcuReq) begin
                pending  = 1'b1;
                cnt      = latMode ? int'($urandom_range(1, 4)) : fixedLat;
                pendAddr = mcuAddr;
                latQ.push_back(cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (oamWe) writeQ.push_back({oamAddr, oamData});
        if (mcuReq) readQ.push_back(mcuAddr);
        if (busy) busyCycles++;
    end

    task automatic clearLog();
        writeQ.delete();
        readQ.delete();
        latQ.delete();
        busyCycles = 0;
    endtask

    task automatic trigger(input logic [7:0] d);
        @(negedge clk);
        dmaWe = 1'b1;
        dmaData = d;
        @(negedge clk);
        dmaWe = 1'b0;
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, dmaReg, mcuAddr, mcuReq, oamWe, oamAddr, oamData} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b dma=%h addr=%h req=%b we=%b oamAddr=%h oamData=%h, expected all zero",
                     busy, dmaReg, mcuAddr, mcuReq, oamWe, oamAddr, oamData);
        end
        vectors++;
        if ({busy1, dmaReg1, mcuAddr1, mcuReq1, oamWe1, oamAddr1, oamData1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_n1: got busy=%b dma=%h addr=%h, expected all zero", busy1, dmaReg1, mcuAddr1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Checks the write list and read addresses of one uninterrupted transfer from page p.
    task automatic checkTransfer(input string name, input logic [7:0] p, input int expBusy);
        vectors++;
        if (writeQ.size() != 160 || readQ.size() != 160) begin
            miscompares++;
            $display("FAIL %s_count: got writes=%0d reads=%0d, expected 160/160", name, writeQ.size(), readQ.size());
            return;
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (writeQ[i] !== {8'(i), mem[{p, 8'(i)}]} || readQ[i] !== {p, 8'(i)}) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got write=%h read=%h, expected write=%h read=%h",
                         name, i, writeQ[i], readQ[i], {8'(i), mem[{p, 8'(i)}]}, {p, 8'(i)});
            end
        end
        vectors++;
        if (busyCycles != expBusy) begin
            miscompares++;
            $display("FAIL %s_busy: got %0d cycles, expected %0d", name, busyCycles, expBusy);
        end
    endtask

    task automatic test_basic_copy();
        bit ok;
        latMode = 1'b0; fixedLat = 1; strayEn = 1'b0;
        clearLog();
        trigger(8'hC0);
        vectors++;
        if (busy !== 1'b1 || mcuReq !== 1'b1 || mcuAddr !== 16'hC000) begin
            miscompares++;
            $display("FAIL basic_first_cycle: got busy=%b req=%b addr=%h, expected 1/1/c000", busy, mcuReq, mcuAddr);
        end
        waitIdle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_timeout: still busy, expected idle");
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem[16'hC000 + 16'(i * 50)] !== (8'(i * 50) ^ 8'h5A)) begin
                miscompares++;
                $display("FAIL basic_pattern%0d: mem setup inconsistent", i);
            end
        end
        checkTransfer("basic", 8'hC0, 480);
        vectors++;
        if (dmaReg !== 8'hC0 || mcuAddr !== 16'h0000) begin
            miscompares++;
            $display("FAIL basic_after: got dma=%h addr=%h, expected c0/0000", dmaReg, mcuAddr);
        end
    endtask

    task automatic test_echo();
        bit ok;
        latMode = 1'b0; fixedLat = 1; strayEn = 1'b0;
        clearLog();
        trigger(8'hE1);
        waitIdle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL echo_timeout: still busy, expected idle");
        end
        checkTransfer("echo", 8'hC1, 480);
        vectors++;
        if (dmaReg !== 8'hE1) begin
            miscompares++;
            $display("FAIL echo_readback: got %h, expected e1", dmaReg);
        end
    endtask

    task automatic test_variable_latency(input logic [7:0] d);
        bit ok;
        int expBusy;
        latMode = 1'b1; strayEn = 1'b1;
        clearLog();
        trigger(d);
        waitIdle(ok);
        strayEn = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL varlat_timeout: still busy, expected idle");
        end
        repeat (4) @(negedge clk);
        expBusy = 0;
        foreach (latQ[i]) expBusy += 2 + latQ[i];
        checkTransfer("varlat", mapPage(d), expBusy);
    endtask

    task automatic test_restart();
        bit ok;
        bit found;
        latMode = 1'b0; fixedLat = 1; strayEn = 1'b0;
        clearLog();
        trigger(8'hC0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (oamWe && oamAddr == 8'd50) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL restart_find: write of index 50 never seen, expected one");
        end
        dmaWe = 1'b1;
        dmaData = 8'hD0;
        @(negedge clk);
        dmaWe = 1'b0;
        vectors++;
        if (mcuReq !== 1'b1 || mcuAddr !== 16'hD000 || dmaReg !== 8'hD0) begin
            miscompares++;
            $display("FAIL restart_req: got req=%b addr=%h dma=%h, expected 1/d000/d0", mcuReq, mcuAddr, dmaReg);
        end
        waitIdle(ok);
        vectors++;
        if (!ok || writeQ.size() != 211 || readQ.size() != 211 || busyCycles != 633) begin
            miscompares++;
            $display("FAIL restart_counts: got writes=%0d reads=%0d busy=%0d, expected 211/211/633",
                     writeQ.size(), readQ.size(), busyCycles);
            return;
        end
        for (int i = 0; i < 211; i++) begin
            logic [15:0] expW, expR;
            if (i <= 50) begin
                expR = {8'hC0, 8'(i)};
                expW = {8'(i), 8'(i) ^ 8'h5A};
            end else begin
                expR = {8'hD0, 8'(i - 51)};
                expW = {8'(i - 51), mem[expR]};
            end
            vectors++;
            if (writeQ[i] !== expW || readQ[i] !== expR) begin
                miscompares++;
                $display("FAIL restart_byte%0d: got write=%h read=%h, expected write=%h read=%h",
                         i, writeQ[i], readQ[i], expW, expR);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int idx10;
        latMode = 1'b0; fixedLat = 5; strayEn = 1'b0;
        clearLog();
        trigger(8'hC0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (mcuReq && mcuAddr == 16'hC00A) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rstmid_find: request for c00a never seen, expected one");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, dmaReg, mcuAddr, mcuReq, oamWe, oamAddr, oamData} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got busy=%b dma=%h addr=%h req=%b we=%b oamAddr=%h oamData=%h, expected all zero",
                     busy, dmaReg, mcuAddr, mcuReq, oamWe, oamAddr, oamData);
        end
        repeat (10) @(negedge clk);
        idx10 = 0;
        foreach (writeQ[i]) if (writeQ[i][15:8] == 8'd10) idx10++;
        vectors++;
        if (writeQ.size() != 10 || idx10 != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_writes: got writes=%0d idx10=%0d busy=%b, expected 10/0/0", writeQ.size(), idx10, busy);
        end
        fixedLat = 1;
    endtask

    task automatic test_num_bytes_one();
        logic [7:0] x;
        int strobes;
        x = 8'($urandom);
        @(negedge clk);
        dmaWe1 = 1'b1;
        dmaData1 = 8'hF0;
        @(negedge clk);
        dmaWe1 = 1'b0;
        vectors++;
        if (busy1 !== 1'b1 || mcuReq1 !== 1'b1 || mcuAddr1 !== 16'hD000 || dmaReg1 !== 8'hF0) begin
            miscompares++;
            $display("FAIL n1_req: got busy=%b req=%b addr=%h dma=%h, expected 1/1/d000/f0", busy1, mcuReq1, mcuAddr1, dmaReg1);
        end
        @(negedge clk);
        vectors++;
        if (busy1 !== 1'b1 || mcuReq1 !== 1'b0 || oamWe1 !== 1'b0) begin
            miscompares++;
            $display("FAIL n1_wait: got busy=%b req=%b we=%b, expected 1/0/0", busy1, mcuReq1, oamWe1);
        end
        rdValid1 = 1'b1;
        rdData1 = x;
        @(negedge clk);
        rdValid1 = 1'b0;
        vectors++;
        if (oamWe1 !== 1'b1 || oamAddr1 !== 8'd0 || oamData1 !== x || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL n1_write: got we=%b addr=%h data=%h busy=%b, expected 1/00/%h/1", oamWe1, oamAddr1, oamData1, busy1, x);
        end
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mcuReq1 || oamWe1 || busy1) strobes++;
        end
        vectors++;
        if (strobes != 0 || mcuAddr1 !== 16'h0000 || oamData1 !== x) begin
            miscompares++;
            $display("FAIL n1_idle: got activeCycles=%0d addr=%h data=%h, expected 0/0000/%h", strobes, mcuAddr1, oamData1, x);
        end
    endtask

    initial begin
        rst = 1'b1;
        dmaWe = 1'b0; dmaData = '0;
        dmaWe1 = 1'b0; dmaData1 = '0;
        rdValid1 = 1'b0; rdData1 = '0;
        busyCycles = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) mem[16'hC000 + 16'(a)] = 8'(a) ^ 8'h5A;

        test_reset();
        test_basic_copy();
        test_echo();
        test_variable_latency(8'($urandom));
        test_variable_latency(8'hE0 + 8'($urandom_range(0, 31)));
        test_restart();
        test_reset_mid();
        test_num_bytes_one();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
